// File: rtl/learn_mode_ctrl_pkg.sv
// Shared definitions for the piano learn-mode slice: note/mode codes, FSM states, LED helper.
// Optional hint playback is selected with the LEARN_HINT_EN macro.
package learn_mode_ctrl_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_RE   = 4'd2;
  localparam logic [3:0] NOTE_MI   = 4'd3;
  localparam logic [3:0] NOTE_FA   = 4'd4;
  localparam logic [3:0] NOTE_SOL  = 4'd5;
  localparam logic [3:0] NOTE_LA   = 4'd6;
  localparam logic [3:0] NOTE_SI   = 4'd7;

  localparam logic [2:0] MODE_FREE  = 3'b100;
  localparam logic [2:0] MODE_AUTO  = 3'b010;
  localparam logic [2:0] MODE_LEARN = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_PROMPT = 3'd2,
    S_PLAY   = 3'd3,
    S_ADV    = 3'd4,
    S_DONE   = 3'd5
`ifdef LEARN_HINT_EN
    , S_HINT = 3'd6
`endif
  } state_t;

  // Rest and out-of-range codes leave the LED bank dark.
  function automatic logic [6:0] note_to_led(input logic [3:0] n);
    logic [6:0] r;
    r = '0;
    if (n >= NOTE_DO && n <= NOTE_SI) r = 7'b0000001 << (n - 4'd1);
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/learn_song_rom.sv
// Combinational song table indexed by step; a NOTE_REST entry terminates the song.
module learn_song_rom
  import learn_mode_ctrl_pkg::*;
#(
  parameter int IW = 5
) (
  input  logic [IW-1:0] idx,
  output logic [3:0]    note
);

  always_comb begin
    note = NOTE_REST;
    case (int'(idx))
      0:       note = NOTE_DO;
      1:       note = NOTE_MI;
      2:       note = NOTE_SOL;
      default: note = NOTE_REST;
    endcase
  end

endmodule

// File: rtl/learn_mode_ctrl.sv
// Learn-mode sequencer: prompts each song note on the LEDs, scores the player's presses.
// Define LEARN_HINT_EN to play the expected note after a timeout before advancing.
module learn_mode_ctrl
  import learn_mode_ctrl_pkg::*;
#(
  parameter int SONG_LEN    = 32,
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int PLAY_CYC    = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] keys,
  output logic [3:0] note_out,
  output logic [6:0] led_out,
  output logic [7:0] hit_cnt,
  output logic [7:0] miss_cnt,
  output logic       busy,
  output logic       done
);

  localparam int IW   = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
  localparam int TMAX = (TIMEOUT_CYC > PLAY_CYC) ? TIMEOUT_CYC : PLAY_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  // idx carries one extra bit so that idx == SONG_LEN is representable.
  localparam logic [IW:0]   IDX_END   = SONG_LEN[IW:0];
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] PLAY_LAST = TW'(PLAY_CYC - 1);

  state_t        state, state_n;
  logic [IW:0]   idx, idx_n;
  logic [3:0]    exp_note, exp_n, rom_note;
  logic [TW-1:0] timer, timer_n;
  logic [7:0]    hit_n, miss_n;
  logic [6:0]    k_q, k_p, exp_led;
  logic          press;

  learn_song_rom #(.IW(IW)) u_rom (
    .idx  (idx[IW-1:0]),
    .note (rom_note)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= '0;
      k_p <= '0;
    end else begin
      k_q <= keys;
      k_p <= k_q;
    end
  end

  // A press is a clean single key coming out of a fully released keyboard.
  assign press   = (k_q != '0) && ((k_q & (k_q - 7'd1)) == '0) && (k_p == '0);
  assign exp_led = note_to_led(exp_note);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      exp_note <= NOTE_REST;
      timer    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      exp_note <= exp_n;
      timer    <= timer_n;
      hit_cnt  <= hit_n;
      miss_cnt <= miss_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    exp_n    = exp_note;
    timer_n  = timer;
    hit_n    = hit_cnt;
    miss_n   = miss_cnt;
    note_out = NOTE_REST;
    led_out  = '0;
    busy     = (state != S_IDLE) && (state != S_DONE);
    done     = (state == S_DONE);
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          hit_n   = '0;
          miss_n  = '0;
          idx_n   = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        if (idx == IDX_END || rom_note == NOTE_REST) begin
          state_n = S_DONE;
        end else begin
          exp_n   = rom_note;
          timer_n = '0;
          state_n = S_PROMPT;
        end
      end
      S_PROMPT: begin
        led_out = exp_led;
        // A press in the timeout cycle takes priority over the timeout.
        if (press) begin
          if (k_q == exp_led) begin
            hit_n   = sat_inc(hit_cnt);
            timer_n = '0;
            state_n = S_PLAY;
          end else begin
            miss_n  = sat_inc(miss_cnt);
            timer_n = timer + TW'(1);
          end
        end else if (timer >= TO_LAST) begin
          miss_n = sat_inc(miss_cnt);
`ifdef LEARN_HINT_EN
          timer_n = '0;
          state_n = S_HINT;
`else
          state_n = S_ADV;
`endif
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      S_PLAY: begin
        note_out = exp_note;
        if (timer >= PLAY_LAST) state_n = S_ADV;
        else                    timer_n = timer + TW'(1);
      end
`ifdef LEARN_HINT_EN
      S_HINT: begin
        led_out  = exp_led;
        note_out = exp_note;
        if (timer >= PLAY_LAST) state_n = S_ADV;
        else                    timer_n = timer + TW'(1);
      end
`endif
      S_ADV: begin
        idx_n   = idx + 1'b1;
        state_n = S_FETCH;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_learn_mode_ctrl.sv
// Directed scoreboard bench for learn_mode_ctrl with a 3-note song {1,3,5,0}.
module tb_learn_mode_ctrl;

  localparam int SEL_NOTE = 0;
  localparam int SEL_LED  = 1;
  localparam int SEL_HIT  = 2;
  localparam int SEL_MISS = 3;
  localparam int SEL_BUSY = 4;
  localparam int SEL_DONE = 5;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] keys;
  logic [3:0] note_out;
  logic [6:0] led_out;
  logic [7:0] hit_cnt;
  logic [7:0] miss_cnt;
  logic       busy;
  logic       done;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  learn_mode_ctrl #(
    .SONG_LEN    (4),
    .TIMEOUT_CYC (20),
    .PLAY_CYC    (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .keys     (keys),
    .note_out (note_out),
    .led_out  (led_out),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Drive inputs, then advance the given number of cycles; outputs settle 1 ns after each edge.
  task automatic applyStimulus(input logic s, input logic [6:0] k, input logic r, input int cycles);
    start = s;
    keys  = k;
    rst   = r;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectOne(input string tag, input int sel, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic expectAll(input string tag, input logic [3:0] n, input logic [6:0] l,
                           input logic [7:0] h, input logic [7:0] m, input logic b, input logic d);
    expectOne({tag, ".note"}, SEL_NOTE, {4'b0, n});
    expectOne({tag, ".led"},  SEL_LED,  {1'b0, l});
    expectOne({tag, ".hit"},  SEL_HIT,  h);
    expectOne({tag, ".miss"}, SEL_MISS, m);
    expectOne({tag, ".busy"}, SEL_BUSY, {7'b0, b});
    expectOne({tag, ".done"}, SEL_DONE, {7'b0, d});
  endtask

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      SEL_NOTE: return {4'b0, note_out};
      SEL_LED:  return {1'b0, led_out};
      SEL_HIT:  return hit_cnt;
      SEL_MISS: return miss_cnt;
      SEL_BUSY: return {7'b0, busy};
      default:  return {7'b0, done};
    endcase
  endfunction

  task automatic checkOutput();
    exp_t       e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %0h, expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and idle
    applyStimulus(1'b0, 7'h00, 1'b1, 2);
    expectAll("reset", 4'd0, 7'h00, 8'd0, 8'd0, 1'b0, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 7'h00, 1'b0, 1);
    expectAll("idle", 4'd0, 7'h00, 8'd0, 8'd0, 1'b0, 1'b0);
    checkOutput();

    // Start: FETCH then PROMPT for note 1
    applyStimulus(1'b1, 7'h00, 1'b0, 1);
    expectAll("fetch0", 4'd0, 7'h00, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 7'h00, 1'b0, 1);
    expectAll("prompt0", 4'd0, 7'h01, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput();

    // Correct press of note 1
    applyStimulus(1'b0, 7'h01, 1'b0, 1);
    expectOne("press0.led", SEL_LED, 8'h01);
    expectOne("press0.hit", SEL_HIT, 8'd0);
    checkOutput();
    applyStimulus(1'b0, 7'h01, 1'b0, 1);
    expectAll("play0", 4'd1, 7'h00, 8'd1, 8'd0, 1'b1, 1'b0);
    checkOutput();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 7'h00, 1'b0, 1);
      expectOne("play0.hold", SEL_NOTE, 8'd1);
      checkOutput();
    end
    applyStimulus(1'b0, 7'h00, 1'b0, 1);
    expectOne("adv0.note", SEL_NOTE, 8'd0);
    expectOne("adv0.led", SEL_LED, 8'h00);
    checkOutput();
    applyStimulus(1'b0, 7'h00, 1'b0, 2);
    expectOne("prompt1.led", SEL_LED, 8'h04);
    checkOutput();

    // Wrong press, release, then correct press of note 3
    applyStimulus(1'b0, 7'h02, 1'b0, 2);
    expectAll("wrong1", 4'd0, 7'h04, 8'd1, 8'd1, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 7'h00, 1'b0, 2);
    applyStimulus(1'b0, 7'h04, 1'b0, 2);
    expectAll("play1", 4'd3, 7'h00, 8'd2, 8'd1, 1'b1, 1'b0);
    checkOutput();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 7'h00, 1'b0, 1);
      expectOne("play1.hold", SEL_NOTE, 8'd3);
      checkOutput();
    end
    applyStimulus(1'b0, 7'h00, 1'b0, 1);
    expectOne("adv1.note", SEL_NOTE, 8'd0);
    checkOutput();
    applyStimulus(1'b0, 7'h00, 1'b0, 2);
    expectOne("prompt2.led", SEL_LED, 8'h10);
    checkOutput();

    // Timeout on note 5
    applyStimulus(1'b0, 7'h00, 1'b0, 19);
    expectOne("pre_timeout.led", SEL_LED, 8'h10);
    expectOne("pre_timeout.miss", SEL_MISS, 8'd1);
    checkOutput();
    applyStimulus(1'b0, 7'h00, 1'b0, 1);
`ifdef LEARN_HINT_EN
    expectAll("hint_play", 4'd5, 7'h10, 8'd2, 8'd2, 1'b1, 1'b0);
    checkOutput();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 7'h00, 1'b0, 1);
      expectOne("hint_play.hold", SEL_NOTE, 8'd5);
      checkOutput();
    end
    applyStimulus(1'b0, 7'h00, 1'b0, 1);
`endif
    expectAll("timeout_adv", 4'd0, 7'h00, 8'd2, 8'd2, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 7'h00, 1'b0, 2);
    expectAll("done_a", 4'd0, 7'h00, 8'd2, 8'd2, 1'b0, 1'b1);
    checkOutput();

    // Restart from DONE; start while busy is ignored
    applyStimulus(1'b1, 7'h00, 1'b0, 1);
    expectAll("restart", 4'd0, 7'h00, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 7'h00, 1'b0, 1);
    expectOne("re_prompt0.led", SEL_LED, 8'h01);
    checkOutput();
    applyStimulus(1'b1, 7'h00, 1'b0, 1);
    expectAll("start_busy", 4'd0, 7'h01, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput();

    // Multi-key and held-key transitions generate no event
    applyStimulus(1'b0, 7'h05, 1'b0, 3);
    expectAll("multi", 4'd0, 7'h01, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 7'h01, 1'b0, 2);
    expectAll("multi_to_one", 4'd0, 7'h01, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 7'h00, 1'b0, 2);
    applyStimulus(1'b0, 7'h01, 1'b0, 2);
    expectAll("clean0", 4'd1, 7'h00, 8'd1, 8'd0, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 7'h01, 1'b0, 5);
    applyStimulus(1'b0, 7'h01, 1'b0, 2);
    expectOne("held.prompt1", SEL_LED, 8'h04);
    checkOutput();
    applyStimulus(1'b0, 7'h01, 1'b0, 3);
    expectAll("held_across", 4'd0, 7'h04, 8'd1, 8'd0, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 7'h00, 1'b0, 2);
    applyStimulus(1'b0, 7'h04, 1'b0, 2);
    expectAll("clean1", 4'd3, 7'h00, 8'd2, 8'd0, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 7'h00, 1'b0, 5);
    applyStimulus(1'b0, 7'h00, 1'b0, 2);
    expectOne("clean.prompt2", SEL_LED, 8'h10);
    checkOutput();
    applyStimulus(1'b0, 7'h10, 1'b0, 2);
    expectAll("clean2", 4'd5, 7'h00, 8'd3, 8'd0, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 7'h00, 1'b0, 5);
    applyStimulus(1'b0, 7'h00, 1'b0, 2);
    expectAll("done_b", 4'd0, 7'h00, 8'd3, 8'd0, 1'b0, 1'b1);
    checkOutput();

    // Reset in the middle of PLAY, then a fresh lesson from step 0
    applyStimulus(1'b1, 7'h00, 1'b0, 2);
    applyStimulus(1'b0, 7'h01, 1'b0, 2);
    applyStimulus(1'b0, 7'h00, 1'b0, 1);
    expectAll("mid_play", 4'd1, 7'h00, 8'd1, 8'd0, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 7'h00, 1'b1, 2);
    expectAll("rst_mid", 4'd0, 7'h00, 8'd0, 8'd0, 1'b0, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 7'h00, 1'b0, 1);
    expectAll("post_rst", 4'd0, 7'h00, 8'd0, 8'd0, 1'b0, 1'b0);
    checkOutput();
    applyStimulus(1'b1, 7'h00, 1'b0, 1);
    applyStimulus(1'b0, 7'h00, 1'b0, 1);
    expectAll("after_rst_prompt", 4'd0, 7'h01, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
